// File: rtl/bin2bcd_pipe_if.sv
// Sample/result stream bundle for bin2bcd_pipe: input handshake, output handshake and payloads.
interface bin2bcd_pipe_if #(
    parameter int unsigned BIN_W  = 11,
    parameter int unsigned DIGITS = 4,
    parameter int unsigned ID_W   = 4
);
    logic                in_vld;
    logic                in_rdy;
    logic [BIN_W-1:0]    bin;
    logic [ID_W-1:0]     in_id;
    logic                out_vld;
    logic                out_rdy;
    logic [4*DIGITS:0]   bcd;
    logic [ID_W-1:0]     out_id;

    modport master (
        output in_vld, bin, in_id, out_rdy,
        input  in_rdy, out_vld, bcd, out_id
    );

    modport slave (
        input  in_vld, bin, in_id, out_rdy,
        output in_rdy, out_vld, bcd, out_id
    );
endinterface

// File: rtl/bin2bcd_pipe.sv
// Pipelined shift-add-3 binary-to-BCD converter with global-stall valid/ready flow control.
// Define BIN2BCD_SIGNED_EN for two's complement input (sign + magnitude); default is unsigned.
module bin2bcd_pipe #(
    parameter int unsigned BIN_W  = 11,
    parameter int unsigned DIGITS = 4,
    parameter int unsigned SPS    = 2,
    parameter int unsigned ID_W   = 4
) (
    input  logic               clk,
    input  logic               rstn,
    bin2bcd_pipe_if.slave      bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned ACC_W = BCD_W + BIN_W;
    localparam int unsigned N     = (BIN_W + SPS - 1) / SPS;
    localparam int unsigned LAST  = BIN_W - (N - 1) * SPS;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

`ifdef BIN2BCD_SIGNED_EN
    localparam longint unsigned MAX_MAG = 64'd1 << (BIN_W - 1);
`else
    localparam longint unsigned MAX_MAG = (64'd1 << BIN_W) - 64'd1;
`endif

    if (pow10(DIGITS) <= MAX_MAG) begin : g_digits_check
        $error("bin2bcd_pipe: DIGITS too small for BIN_W");
    end
    if (SPS < 1 || SPS > BIN_W) begin : g_sps_check
        $error("bin2bcd_pipe: SPS out of range 1..BIN_W");
    end

    // One adjust-then-shift step per iteration; the magnitude MSB shifts into the BCD field.
    function automatic logic [ACC_W-1:0] dabble(input logic [ACC_W-1:0] a, input int unsigned steps);
        logic [ACC_W-1:0] v;
        v = a;
        for (int unsigned s = 0; s < SPS; s++) begin
            if (s < steps) begin
                for (int unsigned d = 0; d < DIGITS; d++) begin
                    if (v[BIN_W+4*d +: 4] >= 4'd5) v[BIN_W+4*d +: 4] = v[BIN_W+4*d +: 4] + 4'd3;
                end
                v = v << 1;
            end
        end
        return v;
    endfunction

    logic             stall;
    logic             vld_q [0:N];
    logic [ID_W-1:0]  id_q  [0:N];
    logic [BCD_W-1:0] bcd_q [1:N];
    logic [BIN_W-1:0] mag_q [0:N-1];
    logic [BIN_W-1:0] mag_in;

    assign stall      = vld_q[N] && !bus.out_rdy;
    assign bus.in_rdy = !stall;

`ifdef BIN2BCD_SIGNED_EN
    logic sgn_q [0:N];
    logic sgn_in;

    // MSB set implies non-zero, so a negative zero cannot arise.
    always_comb begin
        sgn_in = bus.bin[BIN_W-1];
        mag_in = sgn_in ? BIN_W'(-bus.bin) : bus.bin;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       sgn_q[0] <= 1'b0;
        else if (!stall) sgn_q[0] <= bus.in_vld && sgn_in;
    end

    assign bus.bcd = {sgn_q[N], bcd_q[N]};
`else
    always_comb mag_in = bus.bin;

    assign bus.bcd = {1'b0, bcd_q[N]};
`endif

    assign bus.out_vld = vld_q[N];
    assign bus.out_id  = id_q[N];

    // Stage 0: capture magnitude and tag; payload registers are zero whenever the slot is empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q[0] <= 1'b0;
            id_q[0]  <= '0;
            mag_q[0] <= '0;
        end else if (!stall) begin
            vld_q[0] <= bus.in_vld;
            id_q[0]  <= bus.in_vld ? bus.in_id : '0;
            mag_q[0] <= bus.in_vld ? mag_in : '0;
        end
    end

    for (genvar k = 1; k <= N; k++) begin : g_stage
        localparam int unsigned STEPS = (k == N) ? LAST : SPS;
        logic [ACC_W-1:0] acc_in;
        logic [BCD_W-1:0] bcd_nxt;

        if (k == 1) begin : g_first
            assign acc_in = {BCD_W'(0), mag_q[0]};
        end else begin : g_chain
            assign acc_in = {bcd_q[k-1], mag_q[k-1]};
        end

        if (k < N) begin : g_mid
            logic [BIN_W-1:0] mag_nxt;
            assign {bcd_nxt, mag_nxt} = dabble(acc_in, STEPS);

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)       mag_q[k] <= '0;
                else if (!stall) mag_q[k] <= vld_q[k-1] ? mag_nxt : '0;
            end
        end else begin : g_last
            assign bcd_nxt = BCD_W'(dabble(acc_in, STEPS) >> BIN_W);
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_q[k] <= 1'b0;
                id_q[k]  <= '0;
                bcd_q[k] <= '0;
            end else if (!stall) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= vld_q[k-1] ? id_q[k-1] : '0;
                bcd_q[k] <= vld_q[k-1] ? bcd_nxt : '0;
            end
        end

`ifdef BIN2BCD_SIGNED_EN
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)       sgn_q[k] <= 1'b0;
            else if (!stall) sgn_q[k] <= vld_q[k-1] && sgn_q[k-1];
        end
`endif
    end
endmodule

// File: tb/tb_bin2bcd_pipe.sv
// Self-checking bench for bin2bcd_pipe: arithmetic reference model, scoreboard and latency tracking.
module tb_bin2bcd_pipe;
    localparam int unsigned BIN_W  = 11;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned SPS    = 2;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned N      = (BIN_W + SPS - 1) / SPS;
    localparam int unsigned L      = N + 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_pipe_if #(.BIN_W(BIN_W), .DIGITS(DIGITS), .ID_W(ID_W)) bus ();

    bin2bcd_pipe #(.BIN_W(BIN_W), .DIGITS(DIGITS), .SPS(SPS), .ID_W(ID_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [BCD_W:0]  bcd;
        logic [ID_W-1:0] id;
        int              cyc;
        int              stl;
    } exp_t;

    exp_t q[$];
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;
    bit   front_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits of the value by division, sign from the numeric value.
    function automatic logic [BCD_W:0] model(input logic [BIN_W-1:0] b);
        longint          v;
        logic [BCD_W:0]  r;
        r = '0;
`ifdef BIN2BCD_SIGNED_EN
        v = longint'($signed(b));
`else
        v = longint'({1'b0, b});
`endif
        r[BCD_W] = (v < 0);
        if (v < 0) v = -v;
        for (int d = 0; d < int'(DIGITS); d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Single compare process: outputs checked against the scoreboard every cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            q.delete();
            front_seen = 1'b0;
            chk("rst_out_vld", 64'(bus.out_vld), 64'd0);
            chk("rst_bcd", 64'(bus.bcd), 64'd0);
            chk("rst_out_id", 64'(bus.out_id), 64'd0);
            chk("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
        end else begin
            if (bus.out_vld) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'(bus.out_vld), 64'd0);
                end else begin
                    chk("stream_bcd", 64'(bus.bcd), 64'(q[0].bcd));
                    chk("stream_id", 64'(bus.out_id), 64'(q[0].id));
                    if (!front_seen) begin
                        chk("stream_latency", 64'(cyc - q[0].cyc - (stall_cnt - q[0].stl)), 64'(L));
                        front_seen = 1'b1;
                    end
                end
            end else begin
                chk("idle_bcd_zero", 64'(bus.bcd), 64'd0);
                chk("idle_id_zero", 64'(bus.out_id), 64'd0);
            end
            chk("in_rdy", 64'(bus.in_rdy), 64'(!(bus.out_vld && !bus.out_rdy)));
            if (bus.in_vld && bus.in_rdy)
                q.push_back('{bcd: model(bus.bin), id: bus.in_id, cyc: cyc, stl: stall_cnt});
            if (bus.out_vld && bus.out_rdy && q.size() != 0) begin
                void'(q.pop_front());
                front_seen = 1'b0;
            end
            if (bus.out_vld && !bus.out_rdy) stall_cnt++;
        end
    end

    task automatic drive(input logic v, input logic [BIN_W-1:0] b, input logic [ID_W-1:0] id, input logic r);
        @(posedge clk);
        #1;
        bus.in_vld  = v;
        bus.bin     = b;
        bus.in_id   = id;
        bus.out_rdy = r;
    endtask

    // One sample into an empty pipe; result and latency checked against hand-computed literals.
    task automatic single(input logic [BIN_W-1:0] b, input logic [BCD_W:0] exp, input string name);
        int n;
        drive(1'b1, b, 4'hA, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_vld && n < 40);
        chk({name, "_latency"}, 64'(n), 64'(L));
        chk({name, "_bcd"}, 64'(bus.bcd), 64'(exp));
        chk({name, "_id"}, 64'(bus.out_id), 64'hA);
    endtask

    initial begin
        logic [BCD_W:0]  c_bcd;
        logic [ID_W-1:0] c_id;
        int              val;
        int              n;

        bus.in_vld  = 1'b0;
        bus.bin     = '0;
        bus.in_id   = '0;
        bus.out_rdy = 1'b1;
        #1;
        chk("reset_out_vld", 64'(bus.out_vld), 64'd0);
        chk("reset_bcd", 64'(bus.bcd), 64'd0);
        chk("reset_in_rdy", 64'(bus.in_rdy), 64'd1);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

`ifdef BIN2BCD_SIGNED_EN
        single(11'd1023, 17'h01023, "s_1023");
        single(11'h400,  17'h11024, "s_m1024");
        single(11'd0,    17'h00000, "s_zero");
        single(11'h7FF,  17'h10001, "s_m1");
`else
        single(11'd2047, 17'h02047, "u_2047");
        single(11'h400,  17'h01024, "u_1024");
        single(11'd0,    17'h00000, "u_zero");
        single(11'd999,  17'h00999, "u_999");
`endif

        // Back-to-back sweep of every input code.
        for (int i = 0; i < 2048; i++) begin
`ifdef BIN2BCD_SIGNED_EN
            val = i - 1024;
`else
            val = i;
`endif
            drive(1'b1, BIN_W'(val), ID_W'(i), 1'b1);
        end
        repeat (L + 2) drive(1'b0, '0, '0, 1'b1);
        chk("sweep_drained", 64'(q.size()), 64'd0);

        // Backpressure: 5-cycle out_rdy drop while results are valid.
        for (int i = 0; i < 10; i++) drive(1'b1, BIN_W'($urandom), ID_W'(i), 1'b1);
        @(posedge clk);
        #1;
        bus.out_rdy = 1'b0;
        c_bcd = bus.bcd;
        c_id  = bus.out_id;
        chk("bp_out_vld", 64'(bus.out_vld), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_rdy", 64'(bus.in_rdy), 64'd0);
            chk("bp_bcd_stable", 64'(bus.bcd), 64'(c_bcd));
            chk("bp_id_stable", 64'(bus.out_id), 64'(c_id));
        end
        for (int i = 0; i < 6; i++) drive(1'b1, BIN_W'($urandom), ID_W'(i), 1'b1);
        repeat (L + 2) drive(1'b0, '0, '0, 1'b1);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Random valid/ready traffic.
        for (int i = 0; i < 3000; i++)
            drive(1'(($urandom % 4) != 0), BIN_W'($urandom), ID_W'($urandom), 1'(($urandom % 4) != 0));
        n = 0;
        while (q.size() != 0 && n < 200) begin
            drive(1'b0, '0, '0, 1'b1);
            n++;
        end
        drive(1'b0, '0, '0, 1'b1);
        chk("rand_drained", 64'(q.size()), 64'd0);

        // Reset while the pipe is full and results are valid.
        for (int i = 0; i < 9; i++) drive(1'b1, BIN_W'($urandom), ID_W'(i), 1'b1);
        @(posedge clk);
        #2;
        chk("pre_reset_vld", 64'(bus.out_vld), 64'd1);
        bus.in_vld = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_reset_vld", 64'(bus.out_vld), 64'd0);
        chk("mid_reset_bcd", 64'(bus.bcd), 64'd0);
        chk("mid_reset_id", 64'(bus.out_id), 64'd0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        repeat (L + 3) drive(1'b0, '0, '0, 1'b1);
        chk("post_reset_idle", 64'(bus.out_vld), 64'd0);
`ifdef BIN2BCD_SIGNED_EN
        single(11'd512, 17'h00512, "post_rst");
`else
        single(11'd1500, 17'h01500, "post_rst");
`endif
        repeat (2) drive(1'b0, '0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
